ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares the single-port data RAM between up to NUM_REQ requesters: requester 0 is the processor core, requester 1 is the host/puzzle-input loader, requester 2 is the debug reader.
- Round-robin arbitration with a valid/ready request handshake.
- Registered RAM command stage with a fixed-latency read response.
- Optional locked bursts, so one requester can do atomic read-modify-write sequences; a watchdog releases abandoned locks.

Parameters:
- DATA_WIDTH, 16, RAM word width.
- ADDR_WIDTH, 8, RAM address width (matches the 8-bit address field of instructions).
- NUM_REQ, 3, number of requesters (2..8).
- LOCK_TIMEOUT, 16, idle cycles of a lock owner before a forced release; 0 disables the watchdog.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept (combinational, one-hot or zero).
- req_write  input  NUM_REQ  1 = write, 0 = read.
- req_lock  input  NUM_REQ  hold grant after this beat.
- req_addr  input  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  input  NUM_REQ*DATA_WIDTH  packed write data.
- rsp_valid  output  NUM_REQ  one-cycle read-data strobe per requester.
- rsp_rdata  output  DATA_WIDTH  read data, shared by all requesters, qualified by rsp_valid.
- mem_en  output  1  RAM access strobe (registered).
- mem_we  output  1  RAM write enable (registered).
- mem_addr  output  ADDR_WIDTH  RAM address (registered).
- mem_wdata  output  DATA_WIDTH  RAM write data (registered).
- mem_rdata  input  DATA_WIDTH  RAM read data, valid the cycle after mem_en with mem_we=0.
- grant_id  output  3  index of the last accepted requester (registered).
- locked  output  1  lock is held.
- lock_timeout_err  output  1  one-cycle pulse on forced lock release.

Behaviour:
Reset
- All outputs 0.
- Round-robin pointer rr_ptr = 0, state IDLE, watchdog counter 0.
- Any in-flight access or pending rsp_valid is discarded; no mem_en after reset deasserts until a new acceptance.

Handshake
- A beat is accepted in cycle t when req_valid[i] && req_ready[i].
- req_ready depends combinationally on req_valid and on state only, never on req_write, req_addr or req_wdata.
- At most one req_ready bit is high in any cycle.

Arbitration in IDLE
- The winner is the first valid requester scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
- After an accept, rr_ptr <= winner+1 (mod NUM_REQ).
- With no valid requesters, req_ready = 0 and rr_ptr is held.

Command stage
- In cycle t+1: mem_en = 1; mem_we, mem_addr and mem_wdata are the accepted beat's values; grant_id = winner.
- With no accept in t: mem_en = 0 and mem_we = 0 in t+1; mem_addr and mem_wdata hold their previous values.

Read response
- rsp_valid[winner] = 1 in cycle t+2 for reads only.
- rsp_rdata = mem_rdata, combinational pass-through.
- Writes produce no response.

Throughput
- One accept per cycle, back-to-back. Read responses are pipelined and return in acceptance order.

Lock (states IDLE and LOCKED)
- An accepted beat with req_lock=1 moves the state to LOCKED with owner = winner. locked = 1 from the next cycle.
- In LOCKED, only the owner may receive ready; req_ready[owner] = req_valid[owner].
- In LOCKED, rr_ptr does not advance.
- An accepted owner beat with req_lock=0 returns the state to IDLE after that beat. rr_ptr <= owner+1.

Watchdog (only when LOCK_TIMEOUT != 0)
- In LOCKED, the counter increments every cycle req_valid[owner]=0 and clears on every owner accept.
- When the counter reaches LOCK_TIMEOUT, the state returns to IDLE, rr_ptr <= owner+1, lock_timeout_err pulses 1 cycle, and the counter clears.
- Arbitration resumes in the cycle after the release.

Boundary conditions
- Simultaneous requests from all requesters: served in rotation, each accepted exactly once per NUM_REQ accepts.
- A requester dropping req_valid before acceptance is legal; nothing is issued for it.
- A lock beat that is never accepted has no effect.
- A read followed by a write to the same address in consecutive cycles: the RAM order is preserved, and the read returns the old data.

Test Plan:
- Reset sequence: reset held high for 3 cycles with req_valid=3'b111 -> req_ready=0, mem_en=0, rsp_valid=0 throughout; after release, first accept is requester 0.
- Round-robin: req_valid=3'b111 held for 6 cycles, all writes, addr_i=i, wdata_i=16'h1000+i -> mem_addr sequence 0,1,2,0,1,2; grant_id matches.
- Read latency: requester 1 reads addr 8'h05 in cycle t, RAM model holds 16'hBEEF -> mem_en=1 and mem_we=0 at t+1; rsp_valid=3'b010 with rsp_rdata=16'hBEEF at t+2.
- Locked RMW: requester 0 reads 8'h10 with lock=1, then writes 16'h0042 with lock=0 while requester 2 is valid -> requester 2 gets no ready until after the write; locked=1 only between the two beats.
- Watchdog: LOCK_TIMEOUT=4, requester 1 locks and then goes idle, requester 0 valid -> lock_timeout_err pulses exactly 4 idle cycles after the lock beat; requester 0 accepted in the next cycle.
- Reset mid-read: reset asserted in cycle t+1 of a read -> no rsp_valid in t+2; all outputs 0 and rr_ptr 0 after reset release.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing a single-port data RAM between NUM_REQ requesters,
// with a registered command stage, fixed-latency read responses and lockable bursts.
module ram_port_arbiter #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 8,
    parameter int NUM_REQ      = 3,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_write,
    input  logic [NUM_REQ-1:0]             req_lock,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_WIDTH-1:0]          rsp_rdata,
    output logic                           mem_en,
    output logic                           mem_we,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    output logic [DATA_WIDTH-1:0]          mem_wdata,
    input  logic [DATA_WIDTH-1:0]          mem_rdata,
    output logic [2:0]                     grant_id,
    output logic                           locked,
    output logic                           lock_timeout_err
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT + 1) : 1;
    localparam logic [PW:0] NREQ = (PW+1)'(NUM_REQ);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]         state;
    logic [PW-1:0]      rr_ptr;
    logic [PW-1:0]      owner;
    logic [CW-1:0]      wd_cnt;
    logic [PW-1:0]      win;
    logic [PW:0]        idx;
    logic               found;
    logic               accept;
    logic               wd_hit;
    logic [NUM_REQ-1:0] ready_c;
    logic [NUM_REQ-1:0] rsp_valid_r;

    function automatic logic [PW-1:0] inc_mod(input logic [PW-1:0] x);
        if (x == PW'(NUM_REQ - 1))
            return '0;
        return x + 1'b1;
    endfunction

    // Ready never looks at write/addr/data, and is forced low while in reset.
    always_comb begin
        ready_c = '0;
        win     = rr_ptr;
        found   = 1'b0;
        idx     = '0;
        if (!reset) begin
            if (state == ST_LOCKED) begin
                win            = owner;
                ready_c[owner] = req_valid[owner];
            end else begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    idx = {1'b0, rr_ptr} + (PW+1)'(k);
                    if (idx >= NREQ)
                        idx = idx - NREQ;
                    if (!found && req_valid[idx[PW-1:0]]) begin
                        found = 1'b1;
                        win   = idx[PW-1:0];
                    end
                end
                if (found)
                    ready_c[win] = 1'b1;
            end
        end
    end

    assign accept    = |ready_c;
    assign req_ready = ready_c;

    // Release fires in the idle cycle that brings the owner's idle count to LOCK_TIMEOUT.
    assign wd_hit = (LOCK_TIMEOUT != 0) && (state == ST_LOCKED) && !req_valid[owner]
                    && (wd_cnt == CW'(LOCK_TIMEOUT - 1));
    assign lock_timeout_err = wd_hit;

    assign locked    = (state == ST_LOCKED);
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = mem_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            grant_id    <= '0;
            rsp_valid_r <= '0;
        end else begin
            mem_en <= accept;
            mem_we <= accept & req_write[win];
            if (accept) begin
                mem_addr  <= req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
                mem_wdata <= req_wdata[win*DATA_WIDTH +: DATA_WIDTH];
                grant_id  <= 3'(win);
            end
            if (mem_en && !mem_we)
                rsp_valid_r <= NUM_REQ'(1) << grant_id;
            else
                rsp_valid_r <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            rr_ptr <= '0;
            owner  <= '0;
            wd_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        rr_ptr <= inc_mod(win);
                        if (req_lock[win]) begin
                            state  <= ST_LOCKED;
                            owner  <= win;
                            wd_cnt <= '0;
                        end
                    end
                end
                default: begin
                    if (accept) begin
                        wd_cnt <= '0;
                        if (!req_lock[owner]) begin
                            state  <= ST_IDLE;
                            rr_ptr <= inc_mod(owner);
                        end
                    end else if (wd_hit) begin
                        state  <= ST_IDLE;
                        rr_ptr <= inc_mod(owner);
                        wd_cnt <= '0;
                    end else if (LOCK_TIMEOUT != 0) begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: per-cycle arbitration model in the driver,
// command and read-response queues checked by an independent monitor.
module tb_ram_port_arbiter;

    localparam int LT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  req_valid = '0, req_write = '0, req_lock = '0;
    logic [2:0]  req_ready, rsp_valid;
    logic [23:0] req_addr = '0;
    logic [47:0] req_wdata = '0;
    logic [15:0] rsp_rdata, mem_wdata, mem_rdata;
    logic        mem_en, mem_we, locked, lock_timeout_err;
    logic [7:0]  mem_addr;
    logic [2:0]  grant_id;

    ram_port_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .NUM_REQ(3), .LOCK_TIMEOUT(LT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_lock(req_lock), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .grant_id(grant_id), .locked(locked),
        .lock_timeout_err(lock_timeout_err)
    );

    always #5 clk = ~clk;

    // Single-port RAM with registered read data.
    logic [15:0] ram [256];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    typedef struct {int due; logic we; logic [7:0] addr; logic [15:0] wdata; int id;} cmd_t;
    typedef struct {int due; int id; logic [15:0] data;} rsp_t;

    cmd_t        cmd_q[$];
    rsp_t        rsp_q[$];
    logic [15:0] shadow [256];
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    // Reference model state
    int m_rr = 0, m_owner = 0, m_idle = 0;
    bit m_locked = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compare registered outputs shortly after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (cmd_q.size() > 0 && cmd_q[0].due == cyc) begin
                cmd_t c;
                c = cmd_q.pop_front();
                check("mem_en", mem_en, 1'b1);
                check("mem_we", mem_we, c.we);
                check("mem_addr", mem_addr, c.addr);
                check("mem_wdata", mem_wdata, c.wdata);
                check("grant_id", grant_id, c.id);
            end else begin
                check("mem_en_idle", mem_en, 1'b0);
                check("mem_we_idle", mem_we, 1'b0);
            end
            if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
                rsp_t r;
                r = rsp_q.pop_front();
                check("rsp_valid", rsp_valid, 3'b001 << r.id);
                check("rsp_rdata", rsp_rdata, r.data);
            end else begin
                check("rsp_valid_idle", rsp_valid, 3'b000);
            end
        end
    end

    task automatic step(input logic rst, input logic [2:0] v, input logic [2:0] w,
                        input logic [2:0] l, input logic [23:0] a, input logic [47:0] d);
        int          win;
        logic [2:0]  exp_ready;
        logic        exp_err, exp_locked;
        logic [7:0]  ad;
        logic [15:0] wd;
        @(negedge clk);
        reset = rst; req_valid = v; req_write = w; req_lock = l; req_addr = a; req_wdata = d;
        #1;
        win = -1; exp_err = 1'b0; exp_locked = m_locked;
        if (rst) begin
            cmd_q.delete(); rsp_q.delete();
            m_rr = 0; m_locked = 0; m_idle = 0; exp_locked = 1'b0;
        end else if (m_locked) begin
            if (v[m_owner]) begin
                win = m_owner; m_idle = 0;
                if (!l[m_owner]) begin m_locked = 0; m_rr = (m_owner + 1) % 3; end
            end else begin
                m_idle++;
                if (LT != 0 && m_idle == LT) begin
                    exp_err = 1'b1; m_locked = 0; m_idle = 0; m_rr = (m_owner + 1) % 3;
                end
            end
        end else begin
            for (int k = 0; k < 3; k++)
                if (win < 0 && v[(m_rr + k) % 3]) win = (m_rr + k) % 3;
            if (win >= 0) begin
                m_rr = (win + 1) % 3;
                if (l[win]) begin m_locked = 1; m_owner = win; m_idle = 0; end
            end
        end
        exp_ready = (win >= 0) ? (3'b001 << win) : 3'b000;
        check("req_ready", req_ready, exp_ready);
        check("locked", locked, exp_locked);
        check("lock_timeout_err", lock_timeout_err, exp_err);
        if (win >= 0) begin
            ad = a[win*8 +: 8];
            wd = d[win*16 +: 16];
            cmd_q.push_back('{cyc + 1, w[win], ad, wd, win});
            if (w[win]) shadow[ad] = wd;
            else        rsp_q.push_back('{cyc + 2, win, shadow[ad]});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 3'b000, 3'b000, 3'b000, '0, '0);
    endtask

    task automatic check_reset_regs();
        check("rst_mem_addr", mem_addr, 8'h00);
        check("rst_mem_wdata", mem_wdata, 16'h0000);
        check("rst_grant_id", grant_id, 3'd0);
        check("rst_locked", locked, 1'b0);
        check("rst_rsp_valid", rsp_valid, 3'b000);
        check("rst_mem_en", mem_en, 1'b0);
    endtask

    initial begin
        logic [23:0] a;
        logic [47:0] d;

        // Reset held with all requesters valid
        for (int i = 0; i < 3; i++) step(1'b1, 3'b111, 3'b111, 3'b000, '0, '0);
        check_reset_regs();

        // Round-robin writes: addr_i = i, wdata_i = 0x1000 + i
        a = {8'd2, 8'd1, 8'd0};
        d = {16'h1002, 16'h1001, 16'h1000};
        for (int i = 0; i < 6; i++) step(1'b0, 3'b111, 3'b111, 3'b000, a, d);
        idle(2);

        // Preload addresses 0..31 via requester 0; address 5 holds 0xBEEF
        for (int i = 0; i < 32; i++)
            step(1'b0, 3'b001, 3'b001, 3'b000, {16'h0, 8'(i)},
                 {32'h0, (i == 5) ? 16'hBEEF : 16'($urandom)});
        idle(2);

        // Read latency: requester 1 reads 0x05
        step(1'b0, 3'b010, 3'b000, 3'b000, {8'h0, 8'h05, 8'h0}, '0);
        idle(3);

        // Locked read-modify-write by requester 0 with requester 2 competing
        step(1'b0, 3'b001, 3'b000, 3'b001, {8'h0, 8'h0, 8'h10}, '0);
        step(1'b0, 3'b101, 3'b001, 3'b000, {8'h11, 8'h0, 8'h10}, {16'h0, 16'h0, 16'h0042});
        step(1'b0, 3'b100, 3'b000, 3'b000, {8'h10, 8'h0, 8'h0}, '0);
        idle(3);

        // Watchdog: requester 1 locks then abandons; requester 0 waits
        step(1'b0, 3'b010, 3'b000, 3'b010, {8'h0, 8'h04, 8'h0}, '0);
        for (int i = 0; i < 6; i++) step(1'b0, 3'b001, 3'b000, 3'b000, {8'h0, 8'h0, 8'h06}, '0);
        idle(3);

        // Read then write to the same address on consecutive cycles
        step(1'b0, 3'b001, 3'b000, 3'b000, {16'h0, 8'h03}, '0);
        step(1'b0, 3'b001, 3'b001, 3'b000, {16'h0, 8'h03}, {32'h0, 16'h5A5A});
        step(1'b0, 3'b001, 3'b000, 3'b000, {16'h0, 8'h03}, '0);
        idle(3);

        // Reset mid-read: read accepted, reset asserted in the command cycle
        step(1'b0, 3'b100, 3'b000, 3'b000, {8'h07, 16'h0}, '0);
        step(1'b1, 3'b000, 3'b000, 3'b000, '0, '0);
        step(1'b1, 3'b111, 3'b000, 3'b000, '0, '0);
        step(1'b0, 3'b000, 3'b000, 3'b000, '0, '0);
        check_reset_regs();
        step(1'b0, 3'b111, 3'b000, 3'b000, {8'h09, 8'h08, 8'h07}, '0);
        idle(3);

        // Randomized traffic with occasional locks
        for (int i = 0; i < 600; i++) begin
            logic [2:0] v, w, l;
            v = 3'($urandom);
            w = 3'($urandom);
            l = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
            a = {3'b0, 5'($urandom), 3'b0, 5'($urandom), 3'b0, 5'($urandom)};
            d = {16'($urandom), 16'($urandom), 16'($urandom)};
            step(1'b0, v, w, l, a, d);
        end
        idle(LT + 4);

        check("cmd_q_drained", 64'(cmd_q.size()), 64'd0);
        check("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
